cache_controller: RTL and testbench

- Write-back, write-allocate controller for the direct-mapped word cache (32 lines × 32-bit data, one word per line).
- Sits between the rv32i CPU load/store port and the main-memory bus.
- Owns the tag, valid and dirty state internally.
- Sequences the external cache data memory through its we/idx/data-in/data-out port; all accesses take hit or miss paths through a 4-state FSM.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_tag_memory.sv | 45 ++++
 rtl/cache_controller.sv | 159 +++++++++++++++
 tb/tb_cache_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encodings and address-split helpers for the
// direct-mapped write-back word cache controller.
package cache_pkg;

   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = 2;
   localparam int IDX_W    = 5;
   localparam int DATA_W   = 32;
   localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W;
   localparam int LINES    = 2 ** IDX_W;

   typedef logic [1:0] state_t;

   localparam state_t IDLE      = 2'd0;
   localparam state_t COMPARE   = 2'd1;
   localparam state_t WRITEBACK = 2'd2;
   localparam state_t ALLOCATE  = 2'd3;

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W+IDX_W-1:OFFSET_W];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:OFFSET_W+IDX_W];
   endfunction

endpackage

// File: rtl/cache_tag_memory.sv
// Tag, valid and dirty arrays for the cache lines: combinational read,
// synchronous write, valid/dirty bits cleared by the asynchronous reset.
module cache_tag_memory
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] idx,
   output logic [TAG_W-1:0] tag,
   output logic             valid,
   output logic             dirty,
   input  logic             fill,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic             set_dirty
);

   logic [TAG_W-1:0] tag_r [LINES];
   logic [LINES-1:0] valid_r;
   logic [LINES-1:0] dirty_r;

   assign tag   = tag_r[idx];
   assign valid = valid_r[idx];
   assign dirty = dirty_r[idx];

   // A fill installs a clean line; a store hit marks it dirty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         dirty_r <= '0;
      end else if (fill) begin
         valid_r[idx] <= 1'b1;
         dirty_r[idx] <= 1'b0;
      end else if (set_dirty) begin
         dirty_r[idx] <= 1'b1;
      end
   end

   // Tags are only meaningful behind a valid bit, so they carry no reset.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_r[idx] <= fill_tag;
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped word cache.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_controller
   import cache_pkg::*;
(
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              dm_we,
   output logic [IDX_W-1:0]  dm_idx,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   state_t            state_r;
   state_t            next_s;
   logic [IDX_W-1:0]  idx_r;
   logic [TAG_W-1:0]  tag_r;
   logic              we_r;
   logic [DATA_W-1:0] wdata_r;
   logic [TAG_W-1:0]  line_tag_s;
   logic              line_valid_s;
   logic              line_dirty_s;
   logic              hit_s;

   cache_tag_memory u_tags (
      .clk       (iCLK),
      .rst_n     (iRST_N),
      .idx       (idx_r),
      .tag       (line_tag_s),
      .valid     (line_valid_s),
      .dirty     (line_dirty_s),
      .fill      ((state_r == ALLOCATE) && mem_ack),
      .fill_tag  (tag_r),
      .set_dirty ((state_r == COMPARE) && hit_s && we_r)
   );

   assign hit_s = line_valid_s && (line_tag_s == tag_r);

   // Next-state selection; mem_ack only matters while a transfer is open.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE:      if (cpu_req) next_s = COMPARE;  else next_s = IDLE;
         COMPARE:   if (hit_s) next_s = IDLE;
                    else if (line_dirty_s) next_s = WRITEBACK;
                    else next_s = ALLOCATE;
         WRITEBACK: if (mem_ack) next_s = ALLOCATE; else next_s = WRITEBACK;
         ALLOCATE:  if (mem_ack) next_s = COMPARE;  else next_s = ALLOCATE;
         default:   next_s = IDLE;
      endcase
   end

   // Data-memory port: fill data on ALLOCATE completion, store data on a hit.
   always_comb begin
      dm_we    = 1'b0;
      dm_wdata = wdata_r;
      if (state_r == IDLE) begin
         dm_idx = addr_idx(cpu_addr);
      end else begin
         dm_idx = idx_r;
      end
      if (state_r == ALLOCATE) begin
         dm_we    = mem_ack;
         dm_wdata = mem_rdata;
      end else if (state_r == COMPARE) begin
         dm_we    = hit_s && we_r;
         dm_wdata = wdata_r;
      end else begin
         dm_we    = 1'b0;
         dm_wdata = wdata_r;
      end
   end

   // FSM, request latch and registered CPU/memory-bus outputs.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_r   <= IDLE;
         idx_r     <= '0;
         tag_r     <= '0;
         we_r      <= 1'b0;
         wdata_r   <= '0;
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_r   <= next_s;
         cpu_ready <= (state_r == COMPARE) && hit_s;
         mem_req   <= (next_s == WRITEBACK) || (next_s == ALLOCATE);
         mem_we    <= (next_s == WRITEBACK);
         if ((state_r == IDLE) && cpu_req) begin
            idx_r   <= addr_idx(cpu_addr);
            tag_r   <= addr_tag(cpu_addr);
            we_r    <= cpu_we;
            wdata_r <= cpu_wdata;
         end
         if ((state_r == COMPARE) && hit_s && !we_r) begin
            cpu_rdata <= dm_rdata;
         end
         // Victim address/data are captured while dm_rdata still shows the old line.
         if ((state_r == COMPARE) && !hit_s) begin
            if (line_dirty_s) begin
               mem_addr  <= {line_tag_s, idx_r, {OFFSET_W{1'b0}}};
               mem_wdata <= dm_rdata;
            end else begin
               mem_addr  <= {tag_r, idx_r, {OFFSET_W{1'b0}}};
            end
         end else if ((state_r == WRITEBACK) && mem_ack) begin
            mem_addr <= {tag_r, idx_r, {OFFSET_W{1'b0}}};
         end
      end
   end

`ifdef CACHE_CTRL_STATS_EN
   logic replay_r;

   // Replayed COMPARE after a fill is excluded from both counters.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
         replay_r <= 1'b0;
      end else begin
         if ((state_r == ALLOCATE) && mem_ack) begin
            replay_r <= 1'b1;
         end else if (state_r == COMPARE) begin
            replay_r <= 1'b0;
         end
         if (state_r == COMPARE) begin
            if (hit_s) begin
               if (!replay_r) hit_cnt <= hit_cnt + 32'd1;
            end else begin
               miss_cnt <= miss_cnt + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: line-level cache model, memory
// responder with programmable ack delay, and a per-cycle output monitor.
module tb_cache_controller;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_op_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_ready;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        dm_we;
   logic [4:0]  dm_idx;
   logic [31:0] dm_wdata, dm_rdata;
`ifdef CACHE_CTRL_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   cache_controller dut (
      .iCLK(clk), .iRST_N(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .dm_we(dm_we), .dm_idx(dm_idx), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
`ifdef CACHE_CTRL_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   // External cache data memory: combinational read, clocked write.
   logic [31:0] dm_mem [32];
   assign dm_rdata = dm_mem[dm_idx];
   always @(posedge clk) if (dm_we) dm_mem[dm_idx] <= dm_wdata;

   // Reference state
   logic [31:0] mem_model [logic [31:0]];
   bit          m_valid [32];
   bit          m_dirty [32];
   logic [24:0] m_tag   [32];
   logic [31:0] m_data  [32];
   mem_op_t     exp_q [$];
   int          n_checks = 0, n_fail = 0, n_hit = 0, n_miss = 0;
   bit          ready_pending = 1'b0, exp_we = 1'b0, exp_miss = 1'b0, in_access = 1'b0;
   logic [31:0] exp_rdata = 32'd0;
   int          ack_delay = 1;
   bit          hold_ack = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   // Memory responder: acks after ack_delay cycles and checks each transfer.
   initial begin
      int cnt = 0;
      mem_op_t op;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
         end else if (mem_req && rst_n && !hold_ack) begin
            if (cnt >= ack_delay) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_mem_op: got we=%b addr=%h, expected none", mem_we, mem_addr);
               end else begin
                  op = exp_q.pop_front();
                  check("mem_we", {31'd0, mem_we}, {31'd0, op.we});
                  check("mem_addr", mem_addr, op.addr);
                  if (op.we) check("mem_wdata", mem_wdata, op.wdata);
               end
               if (mem_we) mem_model[mem_addr] = mem_wdata;
               else mem_rdata = mem_read(mem_addr);
               mem_ack = 1'b1;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Output monitor: every cpu_ready must match an outstanding access.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (cpu_ready) begin
               if (!ready_pending) begin
                  n_checks++; n_fail++;
                  $display("FAIL spurious_ready: got cpu_ready=1, expected 0");
               end else begin
                  if (!exp_we) check("cpu_rdata", cpu_rdata, exp_rdata);
                  ready_pending = 1'b0;
               end
            end
            if (in_access && !exp_miss) check("no_mem_req_on_hit", {31'd0, mem_req}, 32'd0);
         end
      end
   end

   task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input bit alt);
      logic [4:0]  idx  = addr[6:2];
      logic [24:0] tag  = addr[31:7];
      logic [31:0] line = {addr[31:2], 2'b00};
      bit          hit  = m_valid[idx] && (m_tag[idx] == tag);
      int          cyc  = 0;
      if (hit) n_hit++; else n_miss++;
      if (!hit) begin
         if (m_dirty[idx]) exp_q.push_back('{we: 1'b1, addr: {m_tag[idx], idx, 2'b00}, wdata: m_data[idx]});
         exp_q.push_back('{we: 1'b0, addr: line, wdata: 32'd0});
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_dirty[idx] = 1'b0;
         m_data[idx]  = mem_read(line);
      end
      if (we) begin
         m_data[idx]  = wdata;
         m_dirty[idx] = 1'b1;
      end
      exp_rdata = m_data[idx];
      exp_we = we;
      exp_miss = !hit;
      ready_pending = 1'b1;
      @(negedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      in_access = 1'b1;
      while (ready_pending && cyc < 300) begin
         @(negedge clk); #1;
         cyc++;
         if (cyc == 1 && hit) begin
            check("compare_dm_we", {31'd0, dm_we}, {31'd0, we});
            check("compare_dm_idx", {27'd0, dm_idx}, {27'd0, idx});
            if (we) check("compare_dm_wdata", dm_wdata, wdata);
         end
         if (alt && ready_pending) begin
            cpu_addr  = (cyc % 2 == 1) ? 32'h0000_0F7C : (addr ^ 32'h0000_5000);
            cpu_wdata = $urandom;
            cpu_we    = ~cpu_we;
         end
      end
      cpu_req = 1'b0;
      in_access = 1'b0;
      check("ready_timeout", {31'd0, ready_pending}, 32'd0);
      if (hit) check("hit_latency", cyc, 32'd2);
      check("mem_ops_done", exp_q.size(), 32'd0);
   endtask

   task automatic reset_mid_alloc();
      int cyc = 0;
      hold_ack = 1'b1;
      @(negedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1040;
      @(negedge clk); #1;
      cpu_req = 1'b0;
      while (!mem_req && cyc < 20) begin
         @(negedge clk); #1;
         cyc++;
      end
      check("rst_alloc_req", {31'd0, mem_req}, 32'd1);
      check("rst_alloc_we", {31'd0, mem_we}, 32'd0);
      check("rst_alloc_addr", mem_addr, 32'h0000_1040);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_async_ready", {31'd0, cpu_ready}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      exp_q.delete();
      n_hit = 0;
      n_miss = 0;
      hold_ack = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected end of test");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = 25'd0;
         m_data[i]  = 32'd0;
      end
      mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
      mem_model[32'h0000_0840] = 32'h0840_AAAA;
      mem_model[32'h0000_0C40] = 32'hC0C0_0C40;
      repeat (3) @(negedge clk);
      check("reset_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      check("reset_mem_req", {31'd0, mem_req}, 32'd0);
      check("reset_mem_we", {31'd0, mem_we}, 32'd0);
      check("reset_dm_we", {31'd0, dm_we}, 32'd0);
      check("reset_cpu_rdata", cpu_rdata, 32'd0);
      check("reset_mem_addr", mem_addr, 32'd0);
      check("reset_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;

      access(1'b0, 32'h0000_0040, 32'd0, 1'b0);
      check("cold_load_literal", cpu_rdata, 32'hDEAD_BEEF);
      access(1'b0, 32'h0000_0040, 32'd0, 1'b0);
      access(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0);
      access(1'b0, 32'h0000_0040, 32'd0, 1'b0);
      check("store_then_load_literal", cpu_rdata, 32'h1234_5678);
      access(1'b0, 32'h0000_0840, 32'd0, 1'b0);
      check("evict_wb_literal", mem_read(32'h0000_0040), 32'h1234_5678);
      check("evict_fill_literal", cpu_rdata, 32'h0840_AAAA);
      access(1'b0, 32'h0000_0C40, 32'd0, 1'b0);
      check("clean_miss_literal", cpu_rdata, 32'hC0C0_0C40);

      access(1'b1, 32'h0000_0044, 32'hA1B2_C3D4, 1'b0);
      access(1'b0, 32'h0000_0044, 32'd0, 1'b0);
      access(1'b1, 32'hFFFF_FF80, 32'h0BAD_F00D, 1'b0);
      access(1'b0, 32'h0000_0000, 32'd0, 1'b0);
      access(1'b0, 32'h0000_007C, 32'd0, 1'b0);
      access(1'b0, 32'hFFFF_FF80, 32'd0, 1'b0);
      check("top_tag_literal", cpu_rdata, 32'h0BAD_F00D);

      ack_delay = 5;
      access(1'b0, 32'h0000_2040, 32'd0, 1'b1);
      access(1'b1, 32'h0000_3044, 32'h5555_AAAA, 1'b1);
      repeat (5) @(negedge clk);
      ack_delay = 1;
      access(1'b0, 32'h0000_3044, 32'd0, 1'b0);
      check("alt_store_literal", cpu_rdata, 32'h5555_AAAA);

      reset_mid_alloc();
      access(1'b0, 32'h0000_0040, 32'd0, 1'b0);
      check("post_reset_literal", cpu_rdata, 32'h1234_5678);
      access(1'b0, 32'h0000_0044, 32'd0, 1'b0);
      check("post_reset_wb_literal", cpu_rdata, 32'hA1B2_C3D4);
`ifdef CACHE_CTRL_STATS_EN
      check("hit_cnt", hit_cnt, n_hit);
      check("miss_cnt", miss_cnt, n_miss);
`endif
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
